cnt_updown_tc: RTL and testbench
================================

// Module: cnt_updown_tc
//
// PURPOSE
//  Synchronous loadable up/down counter with terminal-count and overflow
//  flags. Sits directly downstream of the AND-OR merge cells: its count
//  enable en_i is driven by an a32o-style y_o, so the counter advances only
//  in cycles where the gated condition holds. Behaves like a 74x161/191
//  counter chain with ripple-carry output, for synthesis onto liberty74
//  flop cells.
//
// PARAMETERS
//  WIDTH    4  counter width in bits, >= 2
//  RST_VAL  0  value loaded into q_o on reset; must be < 2**WIDTH
//
// PORTS
//  clk_i  input   1      clock, rising edge
//  rst_i  input   1      asynchronous reset, active-high
//  clr_i  input   1      synchronous clear to 0
//  load_i input   1      synchronous parallel load of d_i
//  d_i    input   WIDTH  parallel load data
//  en_i   input   1      count enable (from upstream AND-OR y_o)
//  dir_i  input   1      1 = count up, 0 = count down
//  q_o    output  WIDTH  registered count value
//  tc_o   output  1      combinational terminal count (ripple carry)
//  ovf_o  output  1      registered one-cycle over/underflow pulse
//
// BEHAVIOUR
//  - Reset (rst_i=1, asynchronous, any time including mid-count): q_o=RST_VAL,
//    ovf_o=0 immediately. Counting resumes on the first rising edge after
//    rst_i falls.
//  - Per rising edge, priority clr_i > load_i > en_i:
//      clr_i=1            : q <= 0, ovf <= 0
//      load_i=1           : q <= d_i, ovf <= 0
//      en_i=1, dir_i=1    : q <= q+1 (mod 2**WIDTH, see CONFIGURATION)
//      en_i=1, dir_i=0    : q <= q-1 (mod 2**WIDTH, see CONFIGURATION)
//      otherwise          : q holds, ovf <= 0
//  - tc_o = en_i & ((dir_i & q_o==all-ones) | (~dir_i & q_o==0)).
//    Purely combinational from q_o, en_i, dir_i. Not masked by clr_i/load_i.
//    Allows WIDTH-bit stages to be cascaded by feeding tc_o into the next
//    stage's en_i.
//  - ovf_o <= tc_o & ~clr_i & ~load_i. High for exactly the one cycle after a
//    step was taken or attempted at the limit.
//  - Latency: q_o and ovf_o update one cycle after the sampled inputs.
//    tc_o has zero latency.
//  - Direction change while counting takes effect on the same edge. There is
//    no extra state.
//  - Output ovf_o is never high on two consecutive cycles unless tc_o
//    conditions repeat (saturating mode at the limit with en_i held).
//
// CONFIGURATION
//  CNT_SATURATE_EN
//   - Undefined (default): counter wraps. all-ones+1 -> 0, 0-1 -> all-ones.
//     ovf_o pulses on the wrap.
//   - Defined: counter saturates. At all-ones counting up, or at 0 counting
//     down, q_o holds and ovf_o is asserted each cycle the step is attempted.
//   - tc_o definition is identical in both modes.
//
// TESTING
//  1. rst_i=1 mid-count with q_o=9 (RST_VAL=3) -> q_o=3 and ovf_o=0 before
//     the next edge; q_o holds 3 while rst_i=1.
//  2. load_i=1, d_i=4'hE; then en_i=1, dir_i=1 for 3 cycles.
//     Wrap build: q_o=E,F,0,1; tc_o=1 while q_o=F; ovf_o=1 only in the
//     cycle with q_o=0.
//  3. Saturate build, same stimulus -> q_o=E,F,F,F; ovf_o=1 for 2 cycles.
//  4. Down count from q_o=1, en_i=1, dir_i=0 for 2 cycles.
//     Wrap build: q_o=0 then F, tc_o=1 at q_o=0, ovf_o pulses once.
//  5. clr_i=1, load_i=1, en_i=1 together with q_o=F, d_i=5 -> q_o=0,
//     ovf_o=0; tc_o still 1 during that cycle.
//  6. Two instances cascaded: low tc_o drives high en_i, 8 bits total.
//     Count from 8'h0F up -> 8'h10 on the next edge.
//     Count from 8'hFF up -> 8'h00 on the next edge, with the high stage's
//     ovf_o pulsing.

Source files
------------

// File: rtl/cnt_updown_tc.sv
`default_nettype none
//============================================================================
// Module      : cnt_updown_tc
// Description : Loadable up/down counter with combinational terminal count
//               (ripple carry) and a registered one-cycle over/underflow
//               pulse. Stages cascade by feeding tc_o into the next en_i.
//               Optional macro CNT_SATURATE_EN: when defined, the counter
//               holds at its limit instead of wrapping.
// Revision    : 1.0 - initial release
//============================================================================
module cnt_updown_tc #(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_RST_VAL  = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic [WIDTH-1:0] w_q_next;
    logic             w_ovf_next;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_tc;

    // Limit detection and ripple-carry: tc is deliberately not masked by
    // clr/load so a cascaded stage sees the same carry as the flop does.
    always_comb begin
        w_at_max = (r_q == c_ALL_ONES);
        w_at_min = (r_q == c_ZERO);
        w_tc     = en_i & ((dir_i & w_at_max) | (~dir_i & w_at_min));
    end

    // Next-state selection with priority clear > load > count.
    always_comb begin
        w_q_next   = r_q;
        w_ovf_next = w_tc & ~clr_i & ~load_i;
        if (clr_i) begin
            w_q_next = c_ZERO;
        end else if (load_i) begin
            w_q_next = d_i;
        end else if (en_i) begin
`ifdef CNT_SATURATE_EN
            // At the limit the step is refused; ovf still flags the attempt.
            if (dir_i && !w_at_max) begin
                w_q_next = r_q + c_ONE;
            end else if (!dir_i && !w_at_min) begin
                w_q_next = r_q - c_ONE;
            end
`else
            // Modular arithmetic gives the wrap for free.
            if (dir_i) begin
                w_q_next = r_q + c_ONE;
            end else begin
                w_q_next = r_q - c_ONE;
            end
`endif
        end
    end

    // Count and overflow registers; reset acts immediately, not on an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q   <= c_RST_VAL;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_ovf <= w_ovf_next;
        end
    end

    assign q_o   = r_q;
    assign tc_o  = w_tc;
    assign ovf_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cnt_updown_tc.sv
`default_nettype none
//============================================================================
// Module      : tb_cnt_updown_tc
// Description : Directed self-checking bench for cnt_updown_tc, covering
//               reset, wrap/saturate stepping, priority and an 8-bit cascade.
// Revision    : 1.0 - initial release
//============================================================================
module tb_cnt_updown_tc;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       load;
    logic [3:0] d;
    logic       en;
    logic       dir;
    logic [3:0] q;
    logic       tc;
    logic       ovf;

    // Cascade: low stage enable from bench, high stage enable from low tc
    logic       c_load;
    logic [3:0] lo_d;
    logic [3:0] hi_d;
    logic       c_en;
    logic [3:0] lo_q;
    logic [3:0] hi_q;
    logic       lo_tc;
    logic       hi_tc;
    logic       lo_ovf;
    logic       hi_ovf;

    int errors;
    int checks;

    cnt_updown_tc #(.WIDTH(4), .RST_VAL(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clr),
        .load_i(load),
        .d_i   (d),
        .en_i  (en),
        .dir_i (dir),
        .q_o   (q),
        .tc_o  (tc),
        .ovf_o (ovf)
    );

    cnt_updown_tc #(.WIDTH(4), .RST_VAL(0)) u_lo (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (1'b0),
        .load_i(c_load),
        .d_i   (lo_d),
        .en_i  (c_en),
        .dir_i (1'b1),
        .q_o   (lo_q),
        .tc_o  (lo_tc),
        .ovf_o (lo_ovf)
    );

    cnt_updown_tc #(.WIDTH(4), .RST_VAL(0)) u_hi (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (1'b0),
        .load_i(c_load),
        .d_i   (hi_d),
        .en_i  (lo_tc),
        .dir_i (1'b1),
        .q_o   (hi_q),
        .tc_o  (hi_tc),
        .ovf_o (hi_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load a value into the main counter; returns at the negedge after the load edge
    task automatic load_val(input logic [3:0] v);
        load = 1'b1; d = v; en = 1'b0; clr = 1'b0;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        // Power-up reset value
        checks++; if (q !== 4'h3) begin errors++; $display("FAIL rst_init_q: got %h want %h", q, 4'h3); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_init_ovf: got %b want 0", ovf); end
        rst = 1'b0;
        load_val(4'h9);
        checks++; if (q !== 4'h9) begin errors++; $display("FAIL load9_q: got %h want %h", q, 4'h9); end
        // Asynchronous reset mid-cycle while enabled
        en = 1'b1; dir = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (q !== 4'h3) begin errors++; $display("FAIL rst_async_q: got %h want %h", q, 4'h3); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_async_ovf: got %b want 0", ovf); end
        @(posedge clk); #1;
        checks++; if (q !== 4'h3) begin errors++; $display("FAIL rst_hold_q: got %h want %h", q, 4'h3); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (q !== 4'h4) begin errors++; $display("FAIL rst_resume_q: got %h want %h", q, 4'h4); end
        // Reset must also kill a pending ovf pulse immediately
        load_val(4'hF);
        en = 1'b1; dir = 1'b1;
        @(negedge clk);
`ifdef CNT_SATURATE_EN
        checks++; if (q !== 4'hF) begin errors++; $display("FAIL rst_pre_q: got %h want %h", q, 4'hF); end
`else
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL rst_pre_q: got %h want %h", q, 4'h0); end
`endif
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL rst_pre_ovf: got %b want 1", ovf); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_clr_ovf: got %b want 0", ovf); end
        checks++; if (q !== 4'h3) begin errors++; $display("FAIL rst_clr_q: got %h want %h", q, 4'h3); end
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_count_up;
        logic [3:0] exp_q [4];
        logic       exp_ovf [4];
        logic       exp_tc [4];
        load_val(4'hE);
`ifdef CNT_SATURATE_EN
        exp_q = '{4'hE, 4'hF, 4'hF, 4'hF};
        exp_ovf = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_tc = '{1'b0, 1'b1, 1'b1, 1'b1};
`else
        exp_q = '{4'hE, 4'hF, 4'h0, 4'h1};
        exp_ovf = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_tc = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif
        en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) en = 1'b0;
            #1;
            checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL up_q[%0d]: got %h want %h", i, q, exp_q[i]); end
            checks++; if (ovf !== exp_ovf[i]) begin errors++; $display("FAIL up_ovf[%0d]: got %b want %b", i, ovf, exp_ovf[i]); end
            if (i < 3) begin
                checks++; if (tc !== exp_tc[i]) begin errors++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc, exp_tc[i]); end
            end
            @(negedge clk);
        end
        // Enable dropped: ovf must clear
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL up_idle_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_count_down;
        load_val(4'h1);
        en = 1'b1; dir = 1'b0;
        #1;
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dn_tc_at1: got %b want 0", tc); end
        @(negedge clk);
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL dn_q0: got %h want %h", q, 4'h0); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dn_tc_at0: got %b want 1", tc); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dn_ovf0: got %b want 0", ovf); end
        @(negedge clk);
`ifdef CNT_SATURATE_EN
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL dn_q1: got %h want %h", q, 4'h0); end
`else
        checks++; if (q !== 4'hF) begin errors++; $display("FAIL dn_q1: got %h want %h", q, 4'hF); end
`endif
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL dn_ovf1: got %b want 1", ovf); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dn_ovf2: got %b want 0", ovf); end
    endtask

    task automatic test_priority;
        load_val(4'hF);
        clr = 1'b1; load = 1'b1; en = 1'b1; dir = 1'b1; d = 4'h5;
        #1;
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL pri_tc: got %b want 1", tc); end
        @(negedge clk);
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL pri_clr_q: got %h want %h", q, 4'h0); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL pri_clr_ovf: got %b want 0", ovf); end
        // Load beats count
        clr = 1'b0;
        @(negedge clk);
        checks++; if (q !== 4'h5) begin errors++; $display("FAIL pri_load_q: got %h want %h", q, 4'h5); end
        // Hold when idle, and direction change takes effect immediately
        load = 1'b0; en = 1'b0;
        @(negedge clk);
        checks++; if (q !== 4'h5) begin errors++; $display("FAIL hold_q: got %h want %h", q, 4'h5); end
        en = 1'b1; dir = 1'b1;
        @(negedge clk);
        dir = 1'b0;
        @(negedge clk);
        checks++; if (q !== 4'h5) begin errors++; $display("FAIL dirchg_q: got %h want %h", q, 4'h5); end
        en = 1'b0;
    endtask

    task automatic test_cascade;
        c_load = 1'b1; lo_d = 4'hF; hi_d = 4'h0; c_en = 1'b0;
        @(negedge clk);
        c_load = 1'b0; c_en = 1'b1;
        #1;
        checks++; if (lo_tc !== 1'b1) begin errors++; $display("FAIL cas_lo_tc: got %b want 1", lo_tc); end
        @(negedge clk);
`ifdef CNT_SATURATE_EN
        checks++; if ({hi_q, lo_q} !== 8'h1F) begin errors++; $display("FAIL cas_0F: got %h want %h", {hi_q, lo_q}, 8'h1F); end
`else
        checks++; if ({hi_q, lo_q} !== 8'h10) begin errors++; $display("FAIL cas_0F: got %h want %h", {hi_q, lo_q}, 8'h10); end
`endif
        checks++; if (hi_ovf !== 1'b0) begin errors++; $display("FAIL cas_hi_ovf0: got %b want 0", hi_ovf); end
        c_load = 1'b1; lo_d = 4'hF; hi_d = 4'hF; c_en = 1'b0;
        @(negedge clk);
        c_load = 1'b0; c_en = 1'b1;
        #1;
        checks++; if (hi_tc !== 1'b1) begin errors++; $display("FAIL cas_hi_tc: got %b want 1", hi_tc); end
        @(negedge clk);
`ifdef CNT_SATURATE_EN
        checks++; if ({hi_q, lo_q} !== 8'hFF) begin errors++; $display("FAIL cas_FF: got %h want %h", {hi_q, lo_q}, 8'hFF); end
`else
        checks++; if ({hi_q, lo_q} !== 8'h00) begin errors++; $display("FAIL cas_FF: got %h want %h", {hi_q, lo_q}, 8'h00); end
`endif
        checks++; if (hi_ovf !== 1'b1) begin errors++; $display("FAIL cas_hi_ovf1: got %b want 1", hi_ovf); end
        c_en = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; clr = 1'b0; load = 1'b0; d = 4'h0; en = 1'b0; dir = 1'b0;
        c_load = 1'b0; lo_d = 4'h0; hi_d = 4'h0; c_en = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_count_up;
        test_count_down;
        test_priority;
        test_cascade;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
